// File: rtl/nubus_pkg.sv
// nubus_pkg: shared definitions for the NuBus master transfer block.
//   - size codes for the local request (byte / half / word / rejected)
//   - status codes reported back to the requester
//   - transfer FSM state enum
//   - helper that encodes AD[1:0] and /TM0 for the start cycle
package nubus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  localparam logic [1:0] ST_COMPLETE = 2'b00;
  localparam logic [1:0] ST_ERROR    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_RETRY    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_DATA,
    S_DONE
  } state_e;

  // Returns {AD[1:0], /TM0} for the start cycle. These are the same encodings
  // the slave write-strobe decoder turns back into byte, half and word lanes.
  function automatic logic [2:0] start_lo(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: start_lo = {addr_lo, 1'b0};
      SZ_HALF: start_lo = {addr_lo[1], 1'b1, 1'b1};
      default: start_lo = {2'b00, 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/nubus_lane_steer.sv
// nubus_lane_steer: combinational byte-lane steering.
//   size, addr_lo : transfer size code and address bits [1:0]
//   wdata         : right-justified local write data
//   bus_data      : true-polarity data seen on the AD lines
//   wr_lanes      : write data replicated onto every lane it may occupy
//   rd_data       : selected lane, right-justified and zero-extended
module nubus_lane_steer
  import nubus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_data,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_data
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    wr_lanes = wdata;
    rd_data  = bus_data;
    case (size)
      SZ_BYTE: begin
        wr_lanes = {4{wdata[7:0]}};
        rd_data  = {24'h0, bus_data[{addr_lo, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        wr_lanes = {2{wdata[15:0]}};
        rd_data  = addr_lo[1] ? {16'h0, bus_data[31:16]}
                              : {16'h0, bus_data[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/nubus_master_xfer.sv
// nubus_master_xfer: single-transfer NuBus initiator.
//   Local side : mst_req/mst_write/mst_size/mst_addr/mst_wdata in,
//                mst_busy/mst_done/mst_status/mst_rdata out.
//   Arbiter    : arb_rqstn_o (active-low request), arb_grant.
//   Bus        : /START, /ACK, AD, /TM1, /TM0 sampled inputs, drive values
//                and output enables. All bus outputs decode from flops only.
module nubus_master_xfer
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic        mst_req,
  input  logic        mst_write,
  input  logic [1:0]  mst_size,
  input  logic [31:0] mst_addr,
  input  logic [31:0] mst_wdata,
  output logic        mst_busy,
  output logic        mst_done,
  output logic [1:0]  mst_status,
  output logic [31:0] mst_rdata,
  output logic        arb_rqstn_o,
  input  logic        arb_grant,
  input  logic        nub_startn_i,
  input  logic        nub_ackn_i,
  output logic        nub_startn_o,
  input  logic [31:0] nub_adn,
  output logic [31:0] nub_ad_o,
  output logic        nub_ad_oe,
  input  logic        nub_tm1n_i,
  input  logic        nub_tm0n_i,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic        nub_tm_oe
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] wr_lanes;
  logic [31:0] rd_lanes;
  logic [2:0]  lo;

  nubus_lane_steer u_steer (
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .wdata    (wdata_q),
    .bus_data (~nub_adn),
    .wr_lanes (wr_lanes),
    .rd_data  (rd_lanes)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= SZ_WORD;
      cnt_q    <= '0;
      status_q <= ST_COMPLETE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mst_req) begin
          if (mst_size == SZ_BAD) begin
            status_d = ST_ERROR;
            rdata_d  = '0;
            state_d  = S_DONE;
          end else begin
            addr_d  = mst_addr;
            wdata_d = mst_wdata;
            write_d = mst_write;
            size_d  = mst_size;
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        // Take the bus only once the previous tenure has fully ended.
        if (arb_grant && nub_startn_i && nub_ackn_i) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (!nub_ackn_i) begin
          status_d = {~nub_tm1n_i, ~nub_tm0n_i};
          rdata_d  = write_q ? 32'h0 : rd_lanes;
          state_d  = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lo = start_lo(size_q, addr_q[1:0]);

  // Outputs decode from registered state only, so reset drops them at once.
  always_comb begin
    arb_rqstn_o  = 1'b1;
    nub_startn_o = 1'b1;
    nub_ad_o     = '1;
    nub_ad_oe    = 1'b0;
    nub_tm1n_o   = 1'b1;
    nub_tm0n_o   = 1'b1;
    nub_tm_oe    = 1'b0;
    mst_busy     = (state_q != S_IDLE);
    mst_done     = (state_q == S_DONE);
    mst_status   = status_q;
    mst_rdata    = rdata_q;
    case (state_q)
      S_ARB: arb_rqstn_o = 1'b0;
      S_START: begin
        nub_startn_o = 1'b0;
        nub_ad_oe    = 1'b1;
        nub_tm_oe    = 1'b1;
        nub_ad_o     = ~{addr_q[31:2], lo[2:1]};
        nub_tm1n_o   = ~write_q;
        nub_tm0n_o   = lo[0];
      end
      S_DATA: begin
        if (write_q) begin
          nub_ad_oe = 1'b1;
          nub_ad_o  = ~wr_lanes;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/nubus_master_xfer.md
# nubus_master_xfer

Single-transfer NuBus master (initiator) for the card. It takes one local read or write request, arbitrates for the bus, and drives the start cycle with the address and the /TM1, /TM0 transfer-type encoding. It then waits for /ACK, returning read data and the ack status to the local side. It is the initiating counterpart of the slave write-strobe decoder: the address[1:0] and /TM0 encodings it emits are exactly those the slave decodes into byte, half and word lanes.

## Interface
- TIMEOUT_CYCLES, 255: DATA-phase cycles without /ACK before a local timeout is reported (8-bit counter).
- nub_clkn  in  1  NuBus clock; all flops on rising edge.
- nub_resetn  in  1  reset, asynchronous, active-low.
- mst_req  in  1  request strobe, accepted only in IDLE.
- mst_write  in  1  1 = write, 0 = read.
- mst_size  in  2  0 byte, 1 half, 2 word; 3 is rejected.
- mst_addr  in  32  byte address.
- mst_wdata  in  32  write data, right-justified for byte and half.
- mst_busy  out  1  high from accept to DONE inclusive.
- mst_done  out  1  one-cycle completion pulse.
- mst_status  out  2  00 complete, 01 error, 10 timeout, 11 try-again-later; valid with mst_done.
- mst_rdata  out  32  read data, right-justified and zero-extended; valid with mst_done.
- arb_rqstn_o  out  1  bus request to the arbiter, active-low.
- arb_grant  in  1  arbiter grant, active-high.
- nub_startn_i, nub_ackn_i  in  1  bus /START and /ACK, sampled.
- nub_startn_o  out  1  /START drive.
- nub_adn  in  32  bus AD lines (active-low).
- nub_ad_o  out  32  AD drive value, already inverted.
- nub_ad_oe  out  1  AD output enable.
- nub_tm1n_i, nub_tm0n_i  in  1  bus /TM lines.
- nub_tm1n_o, nub_tm0n_o  out  1  /TM drive.
- nub_tm_oe  out  1  /TM output enable.

## Operation
- **Reset values:** all outputs are inactive. This means arb_rqstn_o = 1, nub_startn_o = 1, all *_oe = 0, nub_ad_o = all 1s, /TM outputs = 1, mst_busy = 0, mst_done = 0, mst_status = 00, mst_rdata = 0.
- **States:** IDLE, ARB, START, DATA, DONE.
- **IDLE:**
  - On mst_req with mst_size ≠ 3, latch the request and go to ARB.
  - On mst_req with mst_size = 3, go straight to DONE with status 01 and no bus activity.
- **ARB:** arb_rqstn_o = 0. Go to START when arb_grant = 1, nub_startn_i = 1 and nub_ackn_i = 1 are all seen in the same cycle.
- **START (exactly one cycle):**
  - nub_startn_o = 0; AD and TM enables on.
  - AD[31:2] = addr[31:2].
  - AD[1:0] and /TM0 by size:
    - word: AD[1:0] = 00, /TM0 = 1.
    - half: AD[1:0] = {addr[1],1}, /TM0 = 1.
    - byte: AD[1:0] = addr[1:0], /TM0 = 0.
  - /TM1 = ~write. arb_rqstn_o is released.
- **DATA:**
  - /TM and /START enables off.
  - Write: nub_ad_oe = 1 carrying steered data. Byte data is replicated to all four lanes; half data is replicated to both halves.
  - Read: nub_ad_oe = 0.
  - On the cycle nub_ackn_i = 0, capture status = {~nub_tm1n_i, ~nub_tm0n_i}.
  - On a read ack, extract the lane from ~nub_adn: byte lane addr[1:0], or half addr[1] (1 → bits 31:16).
  - Leave DATA on ack, or when the timeout counter reaches TIMEOUT_CYCLES−1 (status 10, rdata 0).
- **DONE:** all enables off; mst_done = 1; then return to IDLE.
- A status of 11 is reported as-is. The block never retries; retry is the requester's decision.
- mst_req seen outside IDLE is ignored.

## Timing
- Best case for accept → mst_done: IDLE→ARB (1 cycle), ARB with immediate grant (1), START (1), DATA with ack in its first cycle (1), DONE. mst_done is high in cycle 5 after the accept edge.
- Outputs are registered. No combinational path exists from nub_* inputs to nub_* outputs.
- /ACK in the same cycle as START is not possible: ack is sampled only in DATA.
- Reset asserted mid-transfer drops every enable and request asynchronously. No mst_done is generated.
- The timeout counter clears on entry to DATA.

## Structure
- **Package nubus_pkg:**
  - size codes SZ_BYTE / SZ_HALF / SZ_WORD;
  - status codes ST_COMPLETE / ST_ERROR / ST_TIMEOUT / ST_RETRY;
  - the state enum.
- **Sub-module nubus_lane_steer (combinational):** write-data replication and read-data extraction from size and addr[1:0]. It is shared with future block-transfer work.

## Test plan
- **Word write:** addr 0x0000_1004, wdata 0x1122_3344, grant at once, ack with /TM = 11 in DATA cycle 1.
  - START drives AD = ~0x0000_1004, /TM1 = 0, /TM0 = 1.
  - DATA drives AD = ~0x1122_3344.
  - mst_status = 00, and mst_done arrives 5 cycles after accept.
- **Byte write:** addr 0x…03, wdata 0xA5.
  - START drives AD[1:0] = 11, /TM0 = 0.
  - DATA drives 0xA5A5_A5A5.
- **Half read:** addr 0x…02 (half 1). Slave returns ~0xBEEF_0000 with ack.
  - START drives AD[1:0] = 11.
  - mst_rdata = 0x0000_BEEF.
- **No ack:** 255 cycles without ack → mst_status = 10, mst_rdata = 0, all enables off.
- **Arbitration wait and error ack:** grant held off 10 cycles; slave acks with /TM1 = 1, /TM0 = 0.
  - START follows the grant by one cycle.
  - mst_status = 01.
- **Reset and bad size:** reset pulsed during DATA → all outputs return to reset values at once. mst_size = 3 → mst_done with status 01 and no /START.
